// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle for cla_pipe_adder.
// The master drives operands and out_ready. The slave (the adder) returns in_ready and the result.
interface cla_pipe_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/cla_pipe_adder.sv
// Two-level carry-lookahead add/sub with a 2-stage valid/ready pipeline.
// Stage 1 registers bit and group propagate/generate. Stage 2 resolves carries, sum and flags.
module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input logic             clk,
  input logic             rst_n,
  cla_pipe_adder_if.slave bus
);

  localparam int NG = WIDTH / GROUP;

  // Lookahead carry into bit i of one group, as a flat sum of products
  function automatic logic grp_carry(input logic [GROUP-1:0] p, input logic [GROUP-1:0] g,
                                     input logic c, input int i);
    logic acc;
    logic t;
    acc = c;
    for (int m = 0; m < GROUP; m++) acc = acc & ((m < i) ? p[m] : 1'b1);
    for (int k = 0; k < GROUP; k++) begin
      t = (k < i) ? g[k] : 1'b0;
      for (int m = 0; m < GROUP; m++) t = t & ((m > k && m < i) ? p[m] : 1'b1);
      acc = acc | t;
    end
    return acc;
  endfunction

  // Same lookahead at group level: carry into group j, from GP/GG and c0
  function automatic logic top_carry(input logic [NG-1:0] gp, input logic [NG-1:0] gg,
                                     input logic c, input int j);
    logic acc;
    logic t;
    acc = c;
    for (int m = 0; m < NG; m++) acc = acc & ((m < j) ? gp[m] : 1'b1);
    for (int k = 0; k < NG; k++) begin
      t = (k < j) ? gg[k] : 1'b0;
      for (int m = 0; m < NG; m++) t = t & ((m > k && m < j) ? gp[m] : 1'b1);
      acc = acc | t;
    end
    return acc;
  endfunction

  logic             adv_s;
  logic [WIDTH-1:0] b_eff_s;
  logic [WIDTH-1:0] p_d, p_q;
  logic [WIDTH-1:0] g_d, g_q;
  logic [NG-1:0]    gp_d, gp_q;
  logic [NG-1:0]    gg_d, gg_q;
  logic             c0_d, c0_q;
  logic             s1_valid_q;
  logic [NG:0]      gc_s;
  logic [WIDTH-1:0] cb_s;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;
  logic             ovf_d, ovf_q;
  logic             zero_d, zero_q;
  logic             out_valid_q;

  // The whole pipe moves as one unit, so a bubble in stage 1 is simply carried forward
  assign adv_s         = ~out_valid_q | bus.out_ready;
  assign bus.in_ready  = adv_s;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

  // Stage 1 next state: operand conditioning and per-group propagate/generate
  always_comb begin
    b_eff_s = bus.sub ? ~bus.b : bus.b;
    c0_d    = bus.sub ? 1'b1 : bus.cin;
    p_d     = bus.a ^ b_eff_s;
    g_d     = bus.a & b_eff_s;
    gp_d    = '0;
    gg_d    = '0;
    for (int j = 0; j < NG; j++) begin
      gp_d[j] = &p_d[j*GROUP +: GROUP];
      gg_d[j] = grp_carry(p_d[j*GROUP +: GROUP], g_d[j*GROUP +: GROUP], 1'b0, GROUP);
    end
  end

  // Stage 2 next state: group carries, in-group carries, sum and flags
  always_comb begin
    gc_s = '0;
    cb_s = '0;
    for (int j = 0; j <= NG; j++) gc_s[j] = top_carry(gp_q, gg_q, c0_q, j);
    for (int j = 0; j < NG; j++) begin
      for (int i = 0; i < GROUP; i++) begin
        cb_s[j*GROUP + i] = grp_carry(p_q[j*GROUP +: GROUP], g_q[j*GROUP +: GROUP], gc_s[j], i);
      end
    end
    sum_d  = p_q ^ cb_s;
    cout_d = gc_s[NG];
    ovf_d  = cb_s[WIDTH-1] ^ gc_s[NG];
    zero_d = ~|sum_d;
  end

  // Stage 1 register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      p_q        <= '0;
      g_q        <= '0;
      gp_q       <= '0;
      gg_q       <= '0;
      c0_q       <= 1'b0;
    end else if (adv_s) begin
      s1_valid_q <= bus.in_valid;
      p_q        <= p_d;
      g_q        <= g_d;
      gp_q       <= gp_d;
      gg_q       <= gg_d;
      c0_q       <= c0_d;
    end
  end

  // Output register: result fields only update on a real operand set, so they keep the last result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else if (adv_s) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder: WIDTH=16 and WIDTH=32 instances share one stimulus stream.
// Results are scored against an arithmetic reference model.
module tb_cla_pipe_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cla_pipe_adder_if #(.WIDTH(16)) if16 ();
  cla_pipe_adder_if #(.WIDTH(32)) if32 ();

  cla_pipe_adder #(.WIDTH(16), .GROUP(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));
  cla_pipe_adder #(.WIDTH(32), .GROUP(4)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32.slave));

  logic [31:0] a_t = '0;
  logic [31:0] b_t = '0;
  logic        cin_t = 1'b0;
  logic        sub_t = 1'b0;
  logic        in_valid_t = 1'b0;
  logic        out_ready_t = 1'b1;

  assign if16.a = a_t[15:0];
  assign if16.b = b_t[15:0];
  assign if16.cin = cin_t;
  assign if16.sub = sub_t;
  assign if16.in_valid = in_valid_t;
  assign if16.out_ready = out_ready_t;
  assign if32.a = a_t;
  assign if32.b = b_t;
  assign if32.cin = cin_t;
  assign if32.sub = sub_t;
  assign if32.in_valid = in_valid_t;
  assign if32.out_ready = out_ready_t;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  exp_t q16[$];
  exp_t q32[$];
  int   compared = 0;
  int   mismatched = 0;
  int   pops16 = 0;
  bit   acc_in = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: operands as unsigned and signed integers, plain arithmetic
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub);
    exp_t   e;
    longint m, half, aa, bb, sa, sb, sr, full;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    aa   = longint'(a) & m;
    bb   = longint'(b) & m;
    sa   = (aa >= half) ? aa - (m + 1) : aa;
    sb   = (bb >= half) ? bb - (m + 1) : bb;
    if (sub) begin
      full   = aa - bb;
      e.cout = (aa >= bb);
      sr     = sa - sb;
    end else begin
      full   = aa + bb + longint'(cin);
      e.cout = (full > m);
      sr     = sa + sb + longint'(cin);
    end
    e.sum  = 64'(full & m);
    e.ovf  = (sr >= half) || (sr < -half);
    e.zero = ((full & m) == 0);
    return e;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'h0000_0000;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'h8000_8000;
      3:       v = 32'h7FFF_7FFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic score(input string tag, input int w, inout exp_t q[$],
                       input logic ov, input logic [63:0] s, input logic c, input logic o, input logic z);
    exp_t e;
    if (ov && out_ready_t) begin
      if (q.size() == 0) begin
        check({tag, "_spurious"}, 64'(ov), 64'd0);
      end else begin
        e = q.pop_front();
        if (w == 16) pops16++;
        check({tag, "_sum"},  s, e.sum);
        check({tag, "_cout"}, 64'(c), 64'(e.cout));
        check({tag, "_ovf"},  64'(o), 64'(e.ovf));
        check({tag, "_zero"}, 64'(z), 64'(e.zero));
      end
    end
  endtask

  // One clock: observe handshakes just before the edge, then step to 1 time unit past it
  task automatic cycle();
    #1;
    acc_in = in_valid_t && if16.in_ready;
    check("in_ready16", 64'(if16.in_ready), 64'(!if16.out_valid || out_ready_t));
    if (in_valid_t && if16.in_ready) q16.push_back(model(16, a_t, b_t, cin_t, sub_t));
    if (in_valid_t && if32.in_ready) q32.push_back(model(32, a_t, b_t, cin_t, sub_t));
    score("w16", 16, q16, if16.out_valid, 64'(if16.sum), if16.cout, if16.ovf, if16.zero);
    score("w32", 32, q32, if32.out_valid, 64'(if32.sum), if32.cout, if32.ovf, if32.zero);
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sub, input logic [15:0] es,
                          input logic ec, input logic eo, input logic ez);
    a_t = a; b_t = b; cin_t = cin; sub_t = sub;
    in_valid_t = 1'b1; out_ready_t = 1'b1;
    cycle();
    in_valid_t = 1'b0;
    check({tag, "_lat1_valid"}, 64'(if16.out_valid), 64'd0);
    cycle();
    check({tag, "_valid"}, 64'(if16.out_valid), 64'd1);
    check({tag, "_sum"},   64'(if16.sum), 64'(es));
    check({tag, "_cout"},  64'(if16.cout), 64'(ec));
    check({tag, "_ovf"},   64'(if16.ovf), 64'(eo));
    check({tag, "_zero"},  64'(if16.zero), 64'(ez));
    cycle();
  endtask

  initial begin
    logic [15:0] held;
    bit          seen;
    bit          stall_prev;
    int          stall;
    int          sent;
    int          base;
    int          acc_cnt;
    int          cyc;

    // Reset state
    @(posedge clk);
    #1;
    check("rst_out_valid", 64'(if16.out_valid), 64'd0);
    check("rst_sum",       64'(if16.sum), 64'd0);
    check("rst_flags",     64'({if16.cout, if16.ovf, if16.zero}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 64'(if16.in_ready), 64'd1);

    directed("add_wrap", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    directed("add_ovf",  32'h0000_7FFF, 32'h0000_0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    directed("add_cin",  32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
    directed("sub_ovf",  32'h0000_8000, 32'h0000_0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    directed("sub_neg",  32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);

    // Reset with two sets in flight
    in_valid_t = 1'b1; out_ready_t = 1'b1;
    a_t = rand_op(); b_t = rand_op();
    cycle();
    a_t = rand_op(); b_t = rand_op();
    cycle();
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid16", 64'(if16.out_valid), 64'd0);
    check("midrst_out_valid32", 64'(if32.out_valid), 64'd0);
    check("midrst_sum",         64'(if16.sum), 64'd0);
    check("midrst_flags",       64'({if16.cout, if16.ovf, if16.zero}), 64'd0);
    q16.delete();
    q32.delete();
    in_valid_t = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_in_ready", 64'(if16.in_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      check("midrst_no_stale", 64'(if16.out_valid), 64'd0);
      cycle();
    end

    // Backpressure: 5 back-to-back sets, 4-cycle stall after the first result
    seen = 1'b0; stall = 0; stall_prev = 1'b0; sent = 0; base = pops16; held = '0;
    out_ready_t = 1'b1;
    a_t = rand_op(); b_t = rand_op(); cin_t = 1'($urandom_range(0, 1)); sub_t = 1'($urandom_range(0, 1));
    for (int c = 0; c < 40 && (pops16 - base) < 5; c++) begin
      if (stall_prev) begin
        check("bp_in_ready",  64'(if16.in_ready), 64'd0);
        check("bp_out_valid", 64'(if16.out_valid), 64'd1);
        check("bp_sum_held",  64'(if16.sum), 64'(held));
      end
      if (!seen && if16.out_valid) begin
        seen = 1'b1;
        held = if16.sum;
        stall = 4;
      end
      stall_prev  = (stall > 0);
      out_ready_t = (stall > 0) ? 1'b0 : 1'b1;
      if (stall > 0) stall--;
      in_valid_t = (sent < 5);
      cycle();
      if (acc_in) begin
        sent++;
        a_t = rand_op(); b_t = rand_op();
        cin_t = 1'($urandom_range(0, 1)); sub_t = 1'($urandom_range(0, 1));
      end
    end
    check("bp_delivered", 64'(pops16 - base), 64'd5);
    check("bp_queue_empty", 64'(q16.size()), 64'd0);

    // Random traffic with random valid/ready
    acc_cnt = 0;
    cyc = 0;
    while (acc_cnt < 10000 && cyc < 60000) begin
      in_valid_t  = ($urandom_range(0, 3) != 0);
      out_ready_t = ($urandom_range(0, 3) != 0);
      a_t = rand_op(); b_t = rand_op();
      cin_t = 1'($urandom_range(0, 1)); sub_t = 1'($urandom_range(0, 1));
      cycle();
      if (acc_in) acc_cnt++;
      cyc++;
    end
    check("rand_accepted", 64'(acc_cnt), 64'd10000);

    // Drain
    in_valid_t = 1'b0;
    out_ready_t = 1'b1;
    for (int i = 0; i < 10 && (q16.size() + q32.size()) > 0; i++) cycle();
    check("drain16_empty", 64'(q16.size()), 64'd0);
    check("drain32_empty", 64'(q32.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
